// File: rtl/baccarat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : baccarat_pkg                                            |
// | Description: Card code type, rank constants, point lookup and the    |
// |              dealer handshake state encoding.                        |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package baccarat_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_BLANK = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_TEN   = 4'd10;
  localparam card_t CARD_KING  = 4'd13;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } deal_state_t;

  // Ace..9 count face value; ten and court cards (and blank) count zero.
  function automatic logic [3:0] card_points(input card_t card);
    if ((card >= CARD_ACE) && (card < CARD_TEN)) begin
      return card;
    end
    return 4'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/deck_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : deck_counter                                            |
// | Description: Free-running rank counter 1..MAX_RANK that wraps back   |
// |              to 1; never produces 0.                                 |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module deck_counter
  import baccarat_pkg::*;
#(
  parameter int MAX_RANK = 13
) (
  input  logic  clock,
  input  logic  resetb,
  output card_t rank
);

  card_t r_rank;

  // Advance every edge, wrapping from the top rank back to the ace.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_rank <= CARD_ACE;
    end else if (r_rank >= card_t'(MAX_RANK)) begin
      r_rank <= CARD_ACE;
    end else begin
      r_rank <= r_rank + 4'd1;
    end
  end

  assign rank = r_rank;

endmodule
`default_nettype wire

// File: rtl/hand_dealer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : hand_dealer                                             |
// | Description: Deals pseudo-random cards into a baccarat hand over a   |
// |              four-phase req/ack handshake and keeps the hand score.  |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module hand_dealer
  import baccarat_pkg::*;
#(
  parameter int NUM_SLOTS = 3,
  parameter int CARD_W    = 4,
  parameter int MAX_RANK  = 13
) (
  input  logic                        clock,
  input  logic                        resetb,
  input  logic                        deal_req,
  input  logic                        clear_hand,
  output logic                        deal_ack,
  output logic                        deal_err,
  output logic [NUM_SLOTS*CARD_W-1:0] slot_card,
  output logic [1:0]                  card_count,
  output logic                        hand_full,
  output logic [3:0]                  score
);

  card_t                       w_rank;
  deal_state_t                 r_state;
  deal_state_t                 w_state_nxt;
  logic                        w_load;
  logic                        w_err;
  logic                        r_err;
  logic [NUM_SLOTS*CARD_W-1:0] r_slots;
  logic [1:0]                  r_count;
  logic [3:0]                  r_score;
  logic [4:0]                  w_sum;
  logic [3:0]                  w_mod;

  deck_counter #(
    .MAX_RANK (MAX_RANK)
  ) u_deck (
    .clock  (clock),
    .resetb (resetb),
    .rank   (w_rank)
  );

  assign hand_full = (r_count == 2'(NUM_SLOTS));

  // Handshake state register; reset aborts any in-flight handshake.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus load/error decisions; clear suppresses a new request in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (deal_req && !clear_hand) begin
          if (hand_full) begin
            w_err = 1'b1;
          end else begin
            w_load = 1'b1;
          end
          w_state_nxt = ACK;
        end
      end
      ACK: begin
        if (!deal_req) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Point total of the current hand reduced mod 10 by subtraction (max 27).
  always_comb begin
    w_sum = 5'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_sum = w_sum + 5'(card_points(r_slots[i*CARD_W +: CARD_W]));
    end
    if (w_sum >= 5'd20) begin
      w_mod = 4'(w_sum - 5'd20);
    end else if (w_sum >= 5'd10) begin
      w_mod = 4'(w_sum - 5'd10);
    end else begin
      w_mod = 4'(w_sum);
    end
  end

  // Hand contents, fill count, score and the one-cycle full-hand error flag.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_slots <= '0;
      r_count <= 2'd0;
      r_score <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      if (clear_hand) begin
        r_slots <= '0;
        r_count <= 2'd0;
        r_score <= 4'd0;
      end else begin
        r_score <= w_mod;
        if (w_load) begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_count == i[1:0]) begin
              r_slots[i*CARD_W +: CARD_W] <= w_rank;
            end
          end
          r_count <= r_count + 2'd1;
        end
      end
    end
  end

  assign deal_ack   = (r_state == ACK);
  assign deal_err   = r_err;
  assign slot_card  = r_slots;
  assign card_count = r_count;
  assign score      = r_score;

endmodule
`default_nettype wire

// File: tb/tb_hand_dealer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_hand_dealer                                          |
// | Description: Self-checking bench for hand_dealer: vector table,      |
// |              directed corner sequences and random traffic against a  |
// |              queue-based hand model.                                 |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_hand_dealer;

  localparam int NUM_SLOTS = 3;
  localparam int CARD_W    = 4;
  localparam int MAX_RANK  = 13;

  logic                        clock = 1'b0;
  logic                        resetb = 1'b0;
  logic                        deal_req = 1'b0;
  logic                        clear_hand = 1'b0;
  logic                        deal_ack;
  logic                        deal_err;
  logic [NUM_SLOTS*CARD_W-1:0] slot_card;
  logic [1:0]                  card_count;
  logic                        hand_full;
  logic [3:0]                  score;

  hand_dealer #(
    .NUM_SLOTS (NUM_SLOTS),
    .CARD_W    (CARD_W),
    .MAX_RANK  (MAX_RANK)
  ) dut (
    .clock      (clock),
    .resetb     (resetb),
    .deal_req   (deal_req),
    .clear_hand (clear_hand),
    .deal_ack   (deal_ack),
    .deal_err   (deal_err),
    .slot_card  (slot_card),
    .card_count (card_count),
    .hand_full  (hand_full),
    .score      (score)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: hand as a queue, edges counted since reset release.
  int m_edges;
  int m_hand[$];
  bit m_busy;
  bit m_err;
  int m_score;

  typedef struct {
    bit          req;
    bit          clr;
    bit          ack;
    bit          err;
    logic [1:0]  cnt;
    logic [3:0]  scr;
    logic [11:0] slots;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int pts(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int model_deck();
    return (m_edges % MAX_RANK) + 1;
  endfunction

  function automatic logic [11:0] model_slots();
    logic [11:0] v;
    v = '0;
    for (int i = 0; i < m_hand.size(); i++) v[i*4 +: 4] = 4'(m_hand[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_edges = 0;
    m_hand.delete();
    m_busy  = 0;
    m_err   = 0;
    m_score = 0;
  endtask

  task automatic model_edge(input bit req, input bit clr);
    int deck;
    int sum;
    deck = model_deck();
    sum  = 0;
    foreach (m_hand[i]) sum += pts(m_hand[i]);
    m_err = 0;
    if (clr) begin
      m_score = 0;
      m_hand.delete();
      if (m_busy && !req) m_busy = 0;
    end else begin
      m_score = sum % 10;
      if (!m_busy) begin
        if (req) begin
          if (m_hand.size() < NUM_SLOTS) m_hand.push_back(deck);
          else m_err = 1;
          m_busy = 1;
        end
      end else if (!req) begin
        m_busy = 0;
      end
    end
    m_edges++;
  endtask

  task automatic step(input bit req, input bit clr);
    deal_req   = req;
    clear_hand = clr;
    @(posedge clock);
    model_edge(req, clr);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ack"},   32'(deal_ack),   32'(m_busy));
    chk({tag, "_err"},   32'(deal_err),   32'(m_err));
    chk({tag, "_count"}, 32'(card_count), 32'(m_hand.size()));
    chk({tag, "_full"},  32'(hand_full),  32'(m_hand.size() == NUM_SLOTS));
    chk({tag, "_score"}, 32'(score),      32'(m_score));
    chk({tag, "_slots"}, 32'(slot_card),  32'(model_slots()));
    chk({tag, "_deck"},  32'(dut.u_deck.rank), 32'(model_deck()));
  endtask

  task automatic do_reset();
    deal_req   = 0;
    clear_hand = 0;
    resetb     = 0;
    repeat (2) @(negedge clock);
    resetb = 1;
    model_reset();
    #1;
  endtask

  // Idle until the deck will present the wanted rank, then run one handshake.
  task automatic deal_card(input int target);
    int guard;
    guard = 0;
    while (model_deck() != target && guard < 2 * MAX_RANK) begin
      step(0, 0);
      guard++;
    end
    step(1, 0);
    check_model("deal_req");
    step(0, 0);
    check_model("deal_drop");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    // Expected outputs after each edge, starting from reset (deck 1 at edge 0).
    tbl[0]  = '{1, 0, 1, 0, 2'd1, 4'd0, 12'h001};
    tbl[1]  = '{0, 0, 0, 0, 2'd1, 4'd1, 12'h001};
    tbl[2]  = '{1, 1, 0, 0, 2'd0, 4'd0, 12'h000};
    tbl[3]  = '{1, 0, 1, 0, 2'd1, 4'd0, 12'h004};
    tbl[4]  = '{1, 0, 1, 0, 2'd1, 4'd4, 12'h004};
    tbl[5]  = '{0, 0, 0, 0, 2'd1, 4'd4, 12'h004};
    tbl[6]  = '{1, 0, 1, 0, 2'd2, 4'd4, 12'h074};
    tbl[7]  = '{0, 0, 0, 0, 2'd2, 4'd1, 12'h074};
    tbl[8]  = '{1, 0, 1, 0, 2'd3, 4'd1, 12'h974};
    tbl[9]  = '{0, 0, 0, 0, 2'd3, 4'd0, 12'h974};
    tbl[10] = '{1, 0, 1, 1, 2'd3, 4'd0, 12'h974};
    tbl[11] = '{1, 0, 1, 0, 2'd3, 4'd0, 12'h974};
    tbl[12] = '{0, 0, 0, 0, 2'd3, 4'd0, 12'h974};
    tbl[13] = '{0, 1, 0, 0, 2'd0, 4'd0, 12'h000};

    // Reset state
    do_reset();
    chk("rst_ack",   32'(deal_ack),   32'd0);
    chk("rst_err",   32'(deal_err),   32'd0);
    chk("rst_count", 32'(card_count), 32'd0);
    chk("rst_score", 32'(score),      32'd0);
    chk("rst_slots", 32'(slot_card),  32'd0);
    chk("rst_deck",  32'(dut.u_deck.rank), 32'd1);

    // Vector table
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].req, tbl[i].clr);
      chk($sformatf("vec%0d_ack", i),   32'(deal_ack),   32'(tbl[i].ack));
      chk($sformatf("vec%0d_err", i),   32'(deal_err),   32'(tbl[i].err));
      chk($sformatf("vec%0d_count", i), 32'(card_count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_full", i),  32'(hand_full),  32'(tbl[i].cnt == 2'd3));
      chk($sformatf("vec%0d_score", i), 32'(score),      32'(tbl[i].scr));
      chk($sformatf("vec%0d_slots", i), 32'(slot_card),  32'(tbl[i].slots));
      chk($sformatf("vec%0d_deck", i),  32'(dut.u_deck.rank), 32'(((i + 1) % MAX_RANK) + 1));
    end

    // Three deals with a face card, then an over-full request
    do_reset();
    deal_card(12);
    deal_card(7);
    deal_card(9);
    chk("face_slots", 32'(slot_card),  32'h97C);
    chk("face_count", 32'(card_count), 32'd3);
    chk("face_full",  32'(hand_full),  32'd1);
    chk("face_score", 32'(score),      32'd6);
    step(1, 0);
    chk("full_err1",  32'(deal_err),  32'd1);
    chk("full_ack1",  32'(deal_ack),  32'd1);
    chk("full_slots", 32'(slot_card), 32'h97C);
    step(1, 0);
    chk("full_err2",  32'(deal_err),  32'd0);
    chk("full_ack2",  32'(deal_ack),  32'd1);
    step(0, 0);
    chk("full_ack3",  32'(deal_ack),  32'd0);
    check_model("full_end");

    // Reset asserted mid-handshake with the request still held
    step(0, 1);
    step(1, 0);
    check_model("mid_ack");
    #2;
    resetb = 0;
    #1;
    chk("mid_rst_ack",   32'(deal_ack),   32'd0);
    chk("mid_rst_slots", 32'(slot_card),  32'd0);
    chk("mid_rst_count", 32'(card_count), 32'd0);
    @(negedge clock);
    resetb = 1;
    model_reset();
    step(1, 0);
    chk("mid_reload_slot0", 32'(slot_card[3:0]), 32'd1);
    chk("mid_reload_ack",   32'(deal_ack),       32'd1);
    check_model("mid_reload");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(0, 1)), ($urandom % 12) == 0);
      check_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hand_dealer.md
Name: hand_dealer

Overview:
- Upstream feeder for the per-card seven-segment decoders; the decoders consume a 4-bit card code where 1..13 = A..K and 0 = blank.
- Holds one baccarat hand of up to NUM_SLOTS cards.
- A free-running deck counter supplies pseudo-random ranks; each card slot is filled through a four-phase req/ack handshake.
- Also produces the registered hand score (sum of card points mod 10) for the game controller.

Parameters:
- NUM_SLOTS, 3, number of card slots in the hand (1..3)
- CARD_W, 4, width of one card code
- MAX_RANK, 13, highest rank; deck counter wraps MAX_RANK -> 1

Ports:
- clock  in  1  system clock, all state on rising edge
- resetb  in  1  asynchronous active-low reset
- deal_req  in  1  four-phase request to deal one card into the next empty slot
- clear_hand  in  1  synchronous clear of hand, count and score
- deal_ack  out  1  handshake acknowledge
- deal_err  out  1  one-cycle pulse when a request arrives while the hand is full
- slot_card  out  NUM_SLOTS*CARD_W  slot i on bits [i*CARD_W +: CARD_W]; 0 = empty; drives the 7-seg decoders directly
- card_count  out  2  number of filled slots (0..NUM_SLOTS)
- hand_full  out  1  card_count == NUM_SLOTS (combinational from card_count)
- score  out  4  (sum of card points) mod 10, registered

Behaviour:
- Reset (resetb low, asynchronous) sets:
  - deck counter = 1, all slots = 0, card_count = 0, score = 0
  - deal_ack = 0, deal_err = 0, FSM = IDLE
  - Reset asserted mid-handshake aborts it. After release the FSM is in IDLE, so a still-high deal_req is treated as a new request on the next edge.
- Deck counter:
  - Increments every clock edge, sequence 1,2,...,MAX_RANK,1,...
  - Never 0, never above MAX_RANK; unaffected by clear_hand or the FSM.
- Card points: rank 1..9 -> 1..9; ranks 10..13 -> 0.
- FSM states IDLE, ACK; deal_ack = 1 exactly while in ACK (registered).
  - IDLE, deal_req=1, clear_hand=0, !hand_full:
    - slot[card_count] <= deck counter value before this edge
    - card_count += 1
    - go to ACK
  - IDLE, deal_req=1, clear_hand=0, hand_full:
    - no slot change; deal_err = 1 for the next cycle only
    - go to ACK (the requester still completes the handshake)
  - IDLE, clear_hand=1: clear is applied; no capture this edge, stay IDLE. A held deal_req is served on the next edge.
  - ACK, deal_req=1: stay in ACK. No further capture; a held request deals one card only.
  - ACK, deal_req=0: go to IDLE. deal_ack drops one cycle after req drops.
- clear_hand in any state:
  - slots = 0, card_count = 0, score = 0 on that edge
  - FSM state is unaffected; an in-progress ACK completes normally.
- Score:
  - score <= (sum of points of all non-empty slots) mod 10, computed from slot values before the edge.
  - Score therefore lags a slot load by exactly one cycle.
  - Sum fits 5 bits (max 27); reduce with a compare/subtract chain, no divider.
- Latency: request sampled at edge N -> slot and deal_ack valid after N -> score valid after N+1.
- deal_err and a successful load never occur on the same edge.

Decomposition:
- Shared package baccarat_pkg:
  - card_t (logic [3:0]) and rank constants CARD_BLANK=0, CARD_ACE=1, CARD_TEN=10, CARD_KING=13
  - function card_points(card_t) -> logic [3:0]
  - FSM state enum deal_state_t {IDLE, ACK}
- One sub-module: deck_counter (clock, resetb, output card_t rank), a reusable wrap counter parameterised by MAX_RANK.

Test Plan:
- Reset and count:
  - Stimulus: hold resetb=0, then release.
  - Response: slots = 0, score = 0, card_count = 0, deal_ack = 0; deck counter goes 1,2,...,13,1 over 13 edges.
- First deal:
  - Stimulus: after release, deal_req=1 at the first edge.
  - Response: slot0 = 1 and deal_ack = 1 after that edge; score = 1 one edge later. Drop req -> deal_ack = 0 next edge.
- Three deals with face cards:
  - Stimulus: time requests to capture 12, 7, 9.
  - Response: slots = {9,7,12}, card_count = 3, hand_full = 1, score = (0+7+9) mod 10 = 6.
- Fourth request:
  - Stimulus: deal_req while full.
  - Response: deal_err high for one cycle; slots unchanged; deal_ack high until req drops.
- Clear vs deal:
  - Stimulus: clear_hand=1 and deal_req=1 on the same edge in IDLE.
  - Response: hand cleared, score = 0, deal_ack = 0 that edge; next edge slot0 is loaded.
- Reset mid-handshake:
  - Stimulus: assert resetb=0 while in ACK with req held.
  - Response: deal_ack = 0 immediately (asynchronous); after release the held req loads slot0 on the next edge.
